// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and default
// bit period. PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk, reset (sync, active-high), push/wdata, pop, rdata (head,
// 0 when empty), full, empty. A push while full is accepted only with a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells a full ring from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver with FIFO read port and sticky error flags.
// Ports: clk, reset (sync, active-high), ser_rx (async, idle high),
// rd_valid/rd_data/rd_ready (FWFT read handshake), frame_err, parity_err,
// overrun (sticky), err_clr. Define UART_RX_PARITY_EN for 8E1 frames.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ser_rx,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       rd_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    input  logic       err_clr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic sync1, rx_s, rx_prev;
    logic [1:0] fill;
    logic armed;

    uart_rx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [UART_DATA_BITS-1:0] shreg, sh_n;
    logic push, set_fe, set_pe, set_ov;
    logic pop, fifo_full, fifo_empty;

    // fill marks when rx_s carries real line data after reset, so a line
    // that is already low at reset must first go high to arm edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            fill    <= 2'b00;
            armed   <= 1'b0;
        end else begin
            sync1   <= ser_rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
            fill    <= {fill[0], 1'b1};
            armed   <= armed | (fill[1] & rx_s);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_n;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= sh_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) par_bad <= 1'b0;
        else       par_bad <= par_bad_n;
    end
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        sh_n    = shreg;
        push    = 1'b0;
        set_fe  = 1'b0;
        set_pe  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
`endif
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (armed && rx_prev && !rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    sh_n  = {rx_s, shreg[UART_DATA_BITS-1:1]};
                    idx_n = idx + 3'd1;
                    if (idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == LAST) begin
                    cnt_n     = '0;
                    state_n   = STOP;
                    par_bad_n = rx_s != ^shreg;
                    set_pe    = par_bad_n;
                end
            end
`endif
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (!rx_s) set_fe = 1'b1;
`ifdef UART_RX_PARITY_EN
                    else if (!par_bad) push = 1'b1;
`else
                    else push = 1'b1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rd_valid = !fifo_empty;
    assign pop      = rd_valid & rd_ready;
    // A same-cycle pop frees the slot, so only a non-popping full drops.
    assign set_ov   = push & fifo_full & ~pop;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (shreg),
        .pop   (pop),
        .rdata (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= set_fe | (frame_err & ~err_clr);
            overrun   <= set_ov | (overrun & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) parity_err <= 1'b0;
        else       parity_err <= set_pe | (parity_err & ~err_clr);
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16, FIFO depth 4.
// Define UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_rx;

    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int LAT = 2 + C / 2 + 10 * C;
`else
    localparam bit PAR = 1'b0;
    localparam int LAT = 2 + C / 2 + 9 * C;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       ser_rx;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       err_clr;

    int total = 0;
    int bad   = 0;

    uart_rx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ser_rx     (ser_rx),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       par_ok;
        logic       exp_valid;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge ending the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (!PAR && i == 9) continue;
            ser_rx = f[i];
            repeat (C) @(negedge clk);
        end
        ser_rx = 1'b1;
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
        chk({name, "_data"}, 32'(rd_data), 32'(exp));
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit got;
        ser_rx   = 1'b1;
        reset    = 1'b1;
        rd_ready = 1'b0;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_flags", 32'({frame_err, parity_err, overrun}), 32'd0);

        // Line already low when reset releases must be ignored.
        ser_rx = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3 * C * 10) @(negedge clk);
        chk("lowline_valid", 32'(rd_valid), 32'd0);
        chk("lowline_fe", 32'(frame_err), 32'd0);
        ser_rx = 1'b1;
        repeat (20) @(negedge clk);

        // Latency from first low sample to rd_valid.
        n = 0;
        got = 1'b0;
        fork
            send_frame(8'hA5, 1'b1, ^8'hA5);
            begin
                while (!got && n < 400) begin
                    @(posedge clk);
                    n++;
                    #1;
                    if (rd_valid) got = 1'b1;
                end
            end
        join
        chk("latency", 32'(n - 1), 32'(LAT));
        pop_chk("lat_pop", 8'hA5);
        chk("lat_flags", 32'({frame_err, parity_err, overrun}), 32'd0);

        // Start-bit glitch shorter than half a bit.
        ser_rx = 1'b0;
        repeat (C / 2 - 3) @(negedge clk);
        ser_rx = 1'b1;
        repeat (12 * C) @(negedge clk);
        chk("glitch_valid", 32'(rd_valid), 32'd0);
        chk("glitch_flags", 32'({frame_err, parity_err, overrun}), 32'd0);

        vecs.push_back('{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
`else
        vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
`endif

        foreach (vecs[i]) begin
            logic p;
            p = vecs[i].par_ok ? ^vecs[i].d : ~^vecs[i].d;
            send_frame(vecs[i].d, vecs[i].stop, p);
            chk($sformatf("v%0d_valid", i), 32'(rd_valid),
                32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_fe", i), 32'(frame_err),
                32'(vecs[i].exp_fe));
            chk($sformatf("v%0d_pe", i), 32'(parity_err),
                32'(vecs[i].exp_pe));
            chk($sformatf("v%0d_ov", i), 32'(overrun), 32'd0);
            if (vecs[i].exp_valid)
                pop_chk($sformatf("v%0d_pop", i), vecs[i].d);
            chk($sformatf("v%0d_empty", i), 32'(rd_valid), 32'd0);
            clr_err();
            chk($sformatf("v%0d_clr", i),
                32'({frame_err, parity_err, overrun}), 32'd0);
        end

        // Five back-to-back frames into a four-entry FIFO.
        for (int k = 1; k <= 5; k++)
            send_frame(8'(k), 1'b1, ^8'(k));
        chk("ovr_flag", 32'(overrun), 32'd1);
        for (int k = 1; k <= 4; k++)
            pop_chk($sformatf("ovr_pop%0d", k), 8'(k));
        chk("ovr_empty", 32'(rd_valid), 32'd0);
        clr_err();
        chk("ovr_clr", 32'(overrun), 32'd0);

        // Same, but pop in the push cycle of the fifth byte.
        for (int k = 1; k <= 4; k++)
            send_frame(8'(k), 1'b1, ^8'(k));
        fork
            send_frame(8'h05, 1'b1, ^8'h05);
            begin
                repeat (LAT) @(posedge clk);
                #1 rd_ready = 1'b1;
                @(posedge clk);
                #1 rd_ready = 1'b0;
            end
        join
        chk("pp_ovr", 32'(overrun), 32'd0);
        for (int k = 2; k <= 5; k++)
            pop_chk($sformatf("pp_pop%0d", k), 8'(k));
        chk("pp_empty", 32'(rd_valid), 32'd0);

        // Reset in the middle of the data bits of 0xFF.
        fork
            send_frame(8'hFF, 1'b1, ^8'hFF);
            begin
                repeat (4 * C) @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        chk("rstmid_valid", 32'(rd_valid), 32'd0);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        pop_chk("rstmid_pop", 8'h5A);
        chk("rstmid_empty", 32'(rd_valid), 32'd0);
        chk("rstmid_flags", 32'({frame_err, parity_err, overrun}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
